subleq_loader: RTL and testbench

Boot-stage program loader sitting directly upstream of the subleq CPU/memory pair. It accepts a byte stream (host link or testbench), assembles big-endian words, and writes them sequentially into program memory from address 0. Once the image is complete, it releases the CPU through `cpu_run`. While loading, it owns the memory write port and holds the CPU stopped.

---
 rtl/subleq_loader_if.sv | 19 +
 rtl/subleq_loader.sv | 70 +++++++
 tb/tb_subleq_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/subleq_loader_if.sv
// subleq_loader_if: byte-stream, memory-write and status signals between a host and the program loader.
// Ports: start/in_valid/in_data driven by the host; in_ready, mem_we/mem_addr/mem_wdata,
// cpu_run, done and error driven by the loader.
interface subleq_loader_if #(parameter int WORD_SIZE = 16);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 cpu_run;
    logic                 done;
    logic                 error;
    modport master(output start, in_valid, in_data,
                   input in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, error);
    modport slave(input start, in_valid, in_data,
                  output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, error);
endinterface

// File: rtl/subleq_loader.sv
// subleq_loader: assembles a big-endian length-prefixed byte stream into words and writes them from address 0.
// Ports: clk, areset_n (async active-low); bus.slave carries start, the in_valid/in_ready/in_data
// byte stream, the registered mem_we/mem_addr/mem_wdata write port, and cpu_run/done/error status.
module subleq_loader #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_WORDS = 256
) (
    input logic            clk,
    input logic            areset_n,
    subleq_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR} state_t;
    state_t               state, state_nx;
    logic [15:0]          len;
    logic [15:0]          len_in;
    logic [7:0]           word_hi;
    logic [WORD_SIZE-1:0] cnt;
    logic                 xfer;
    assign bus.in_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
    assign bus.done     = state == DONE;
    assign bus.cpu_run  = state == DONE;
    assign bus.error    = state == ERROR;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign len_in       = {len[15:8], bus.in_data};
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = bus.start ? LEN_HI : IDLE;
            LEN_HI:  state_nx = xfer ? LEN_LO : LEN_HI;
            // Oversize check wins over the empty-image check.
            LEN_LO:  state_nx = !xfer ? LEN_LO :
                                {1'b0, len_in} > 17'(MEM_WORDS) ? ERROR :
                                len_in == 16'd0 ? DONE : DATA_HI;
            DATA_HI: state_nx = xfer ? DATA_LO : DATA_HI;
            DATA_LO: state_nx = xfer ? WRITE : DATA_LO;
            WRITE:   state_nx = cnt + 1'b1 == WORD_SIZE'(len) ? DONE : DATA_HI;
            DONE:    state_nx = bus.start ? LEN_HI : DONE;
            ERROR:   state_nx = bus.start ? LEN_HI : ERROR;
            default: state_nx = IDLE;
        endcase
    end
    // Write port is loaded on the last byte so the strobe lands in the WRITE cycle.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            len           <= '0;
            word_hi       <= '0;
            cnt           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= state == DATA_LO && xfer;
            if (xfer && state == LEN_HI) len[15:8] <= bus.in_data;
            if (xfer && state == LEN_LO) begin
                len[7:0] <= bus.in_data;
                cnt      <= '0;
            end
            if (xfer && state == DATA_HI) word_hi <= bus.in_data;
            if (xfer && state == DATA_LO) begin
                bus.mem_addr  <= cnt;
                bus.mem_wdata <= WORD_SIZE'({word_hi, bus.in_data});
            end
            if (state == WRITE) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_subleq_loader.sv
// tb_subleq_loader: scoreboard bench for subleq_loader; expected writes queued as bytes are driven.
module tb_subleq_loader;
    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          writes = 0;
    int          w0;
    logic [31:0] q[$];
    logic [31:0] sb_e;
    int          we_cyc[$];
    logic [15:0] w[$];
    always #5 clk = ~clk;
    subleq_loader_if #(.WORD_SIZE(16)) bus();
    subleq_loader #(.WORD_SIZE(16), .MEM_WORDS(256)) dut(.clk(clk), .areset_n(areset_n), .bus(bus.slave));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            writes++;
            we_cyc.push_back(cyc);
            chk("we_ready_low", 32'(bus.in_ready), 0);
            if (q.size() == 0) chk("we_unexpected", 1, 0);
            else begin
                sb_e = q.pop_front();
                chk("we_addr", 32'(bus.mem_addr), 32'(sb_e[31:16]));
                chk("we_data", 32'(bus.mem_wdata), 32'(sb_e[15:0]));
            end
        end
    end
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (t == 40) begin chk("ready_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic start_pulse();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    task automatic load(input logic [15:0] n, input logic [15:0] wq[$], input int maxgap, input bit skip_len_hi);
        if (!skip_len_hi) send_byte(n[15:8], $urandom_range(maxgap, 0));
        send_byte(n[7:0], $urandom_range(maxgap, 0));
        foreach (wq[i]) begin
            send_byte(wq[i][15:8], $urandom_range(maxgap, 0));
            q.push_back({16'(i), wq[i]});
            send_byte(wq[i][7:0], $urandom_range(maxgap, 0));
        end
    endtask
    task automatic expect_done(input string tag);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_run"}, 32'(bus.cpu_run), 1);
        @(posedge clk); #1;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        #1;
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_status", {29'd0, bus.cpu_run, bus.done, bus.error}, 0);
        repeat (2) @(posedge clk);
        #1 areset_n = 1'b1;
        @(posedge clk); #1;
        // three words back to back
        we_cyc.delete();
        w.delete(); w.push_back(16'h0007); w.push_back(16'h0008); w.push_back(16'hFFFF);
        start_pulse();
        load(16'd3, w, 0, 0);
        @(negedge clk);
        chk("t1_we", 32'(bus.mem_we), 1);
        chk("t1_done_early", 32'(bus.done), 0);
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_run", 32'(bus.cpu_run), 1);
        chk("t1_we_off", 32'(bus.mem_we), 0);
        chk("t1_count", writes, 3);
        if (we_cyc.size() == 3) begin
            chk("t1_gap0", we_cyc[1] - we_cyc[0], 3);
            chk("t1_gap1", we_cyc[2] - we_cyc[1], 3);
        end else chk("t1_we_cycles", we_cyc.size(), 3);
        @(posedge clk); #1;
        // empty image
        w.delete();
        start_pulse();
        load(16'd0, w, 0, 0);
        @(negedge clk);
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_run", 32'(bus.cpu_run), 1);
        chk("t2_count", writes, 3);
        @(posedge clk); #1;
        // oversize length then recovery
        start_pulse();
        load(16'h0101, w, 0, 0);
        @(negedge clk);
        chk("t3_error", 32'(bus.error), 1);
        chk("t3_run", 32'(bus.cpu_run), 0);
        chk("t3_ready", 32'(bus.in_ready), 0);
        chk("t3_done", 32'(bus.done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_count", writes, 3);
        start_pulse();
        @(negedge clk);
        chk("t3_err_clr", 32'(bus.error), 0);
        @(posedge clk); #1;
        w.push_back(16'hABCD);
        load(16'd1, w, 0, 0);
        expect_done("t3");
        chk("t3_err_off", 32'(bus.error), 0);
        // full memory with random stalls
        w.delete();
        for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
        w0 = writes;
        start_pulse();
        load(16'h0100, w, 2, 0);
        expect_done("t4");
        chk("t4_count", writes - w0, 256);
        chk("t4_sb_empty", q.size(), 0);
        // async reset after the 5th data byte of a 4-word load
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        q.push_back({16'd0, 16'h1234});
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        q.push_back({16'd1, 16'h5678});
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h9A, 0);
        #2 areset_n = 1'b0;
        #1;
        chk("t5_ready", 32'(bus.in_ready), 0);
        chk("t5_we", 32'(bus.mem_we), 0);
        chk("t5_addr", 32'(bus.mem_addr), 0);
        chk("t5_wdata", 32'(bus.mem_wdata), 0);
        chk("t5_status", {29'd0, bus.cpu_run, bus.done, bus.error}, 0);
        chk("t5_sb_empty", q.size(), 0);
        @(posedge clk); #1 areset_n = 1'b1;
        @(posedge clk); #1;
        w.delete(); w.push_back(16'h0F0F); w.push_back(16'hF0F0);
        start_pulse();
        load(16'd2, w, 1, 0);
        expect_done("t5");
        // reload from DONE: cpu_run drops on the start edge
        bus.start = 1'b1;
        @(negedge clk);
        chk("t6_run_before", 32'(bus.cpu_run), 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("t6_run_drop", 32'(bus.cpu_run), 0);
        w.delete(); w.push_back(16'h1111); w.push_back(16'h2222);
        send_byte(8'h00, 0);
        load(16'd2, w, 0, 1);
        expect_done("t6");
        repeat (3) @(posedge clk);
        chk("final_sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
